// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit: 32 iterations per operation, {hi, lo} result on prod.
// Define MULT_DIV_SIGNED_EN to enable two's-complement mult/div; otherwise op[0] is ignored.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod,
  output logic        div_by_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic            is_div;
  logic            dbz_pend;
  logic [W-1:0]    divisor;
  logic [2*W-1:0]  work;
  logic [2*W-1:0]  step;
  logic [2*W-1:0]  result;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, rem_shift, diff;
  logic            accept, last;

`ifdef MULT_DIV_SIGNED_EN
  logic sign_op, a_neg, b_neg;
  logic neg_prod, neg_quot, neg_rem;
`else
  logic unused_op_sign;
  assign unused_op_sign = op[0];
`endif

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (count == CW'(W - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes; the iteration always works on unsigned values
  always_comb begin
    a_mag = src_a;
    b_mag = src_b;
`ifdef MULT_DIV_SIGNED_EN
    sign_op = ~op[0];
    a_neg   = sign_op & src_a[W-1];
    b_neg   = sign_op & src_b[W-1];
    if (a_neg) a_mag = -src_a;
    if (b_neg) b_mag = -src_b;
`endif
  end

  // One iteration: shift-add multiply or restoring divide on work = {hi, lo}
  always_comb begin
    mul_sum   = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, divisor} : '0);
    rem_shift = work[2*W-1:W-1];
    diff      = rem_shift - {1'b0, divisor};
    if (!is_div)      step = {mul_sum, work[W-1:1]};
    else if (diff[W]) step = {rem_shift[W-1:0], work[W-2:0], 1'b0};
    else              step = {diff[W-1:0], work[W-2:0], 1'b1};
  end

  // Final sign correction; a zero divisor keeps quotient all-ones and hi = dividend
  always_comb begin
    result = step;
`ifdef MULT_DIV_SIGNED_EN
    if (is_div) begin
      if (neg_rem)  result[2*W-1:W] = -step[2*W-1:W];
      if (neg_quot) result[W-1:0]   = -step[W-1:0];
    end else if (neg_prod) begin
      result = -step;
    end
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      dbz_pend    <= 1'b0;
      divisor     <= '0;
      work        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prod        <= '0;
      div_by_zero <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      neg_prod    <= 1'b0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      busy        <= (state_next == RUN);
      done        <= (state_next == DONE);
      div_by_zero <= last ? dbz_pend : 1'b0;
      if (accept) begin
        count    <= '0;
        is_div   <= op[1];
        dbz_pend <= op[1] && (src_b == '0);
        divisor  <= b_mag;
        work     <= {W'(0), a_mag};
`ifdef MULT_DIV_SIGNED_EN
        neg_prod <= !op[1] && (a_neg ^ b_neg);
        neg_quot <= op[1] && (a_neg ^ b_neg) && (src_b != '0);
        neg_rem  <= op[1] && a_neg;
`endif
      end else if (state == RUN) begin
        work  <= step;
        count <= count + CW'(1);
        if (last) prod <= result;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corners plus randomized ops against an arithmetic model.
// Follows MULT_DIV_SIGNED_EN for expected values.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_by_zero;
  logic [63:0] prod;

  int pass_count = 0;
  int total = 0;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .prod(prod), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference model: {div_by_zero, prod} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    longint sa, sb, q, r, p;
`ifdef MULT_DIV_SIGNED_EN
    sgn = ~o[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!o[1]) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Issue one op at the current negedge and wait (bounded) for done; operands are scrambled during RUN
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output logic d, output int edges,
                        output bit prod_moved, output bit busy_bad);
    logic [63:0] p0;
    p0 = prod;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    edges = 1; prod_moved = 1'b0; busy_bad = 1'b0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (prod !== p0) prod_moved = 1'b1;
      src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
      @(negedge clock);
      edges++;
    end
    p = prod;
    d = div_by_zero;
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_count++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_count++;
    total++; if (prod !== 64'd0) $display("FAIL reset_prod got=%h exp=0", prod); else pass_count++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else pass_count++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult_corners();
    logic [63:0] p, exp_p;
    logic d;
    int e;
    bit pm, bb;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, d, e, pm, bb);
    total++; if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_max got=%h exp=%h", p, 64'hFFFF_FFFE_0000_0001); else pass_count++;
    total++; if (e !== 33) $display("FAIL multu_latency got=%0d exp=33", e); else pass_count++;
    total++; if (d !== 1'b0) $display("FAIL multu_dbz got=%b exp=0", d); else pass_count++;
    total++; if (bb) $display("FAIL multu_busy got=low exp=high during run"); else pass_count++;
    @(negedge clock);
    total++; if (done !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", done); else pass_count++;
`ifdef MULT_DIV_SIGNED_EN
    exp_p = 64'hFFFF_FFFF_FFFF_FFEB;
`else
    exp_p = 64'h0000_0006_FFFF_FFEB;
`endif
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, p, d, e, pm, bb);
    total++; if (p !== exp_p) $display("FAIL mult_neg3x7 got=%h exp=%h", p, exp_p); else pass_count++;
    @(negedge clock);
  endtask

  task automatic test_div_corners();
    logic [63:0] p;
    logic d;
    int e;
    bit pm, bb;
    run_op(2'b11, 32'd100, 32'd7, p, d, e, pm, bb);
    total++; if (p !== 64'h0000_0002_0000_000E) $display("FAIL divu_100_7 got=%h exp=%h", p, 64'h0000_0002_0000_000E); else pass_count++;
    total++; if (pm) $display("FAIL prod_stable_in_run got=changed exp=stable"); else pass_count++;
`ifdef MULT_DIV_SIGNED_EN
    @(negedge clock);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, p, d, e, pm, bb);
    total++; if (p !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg7_2 got=%h exp=%h", p, 64'hFFFF_FFFF_FFFF_FFFD); else pass_count++;
`endif
    @(negedge clock);
    run_op(2'b11, 32'h0000_1234, 32'd0, p, d, e, pm, bb);
    total++; if (p !== 64'h0000_1234_FFFF_FFFF) $display("FAIL divu_by_zero got=%h exp=%h", p, 64'h0000_1234_FFFF_FFFF); else pass_count++;
    total++; if (d !== 1'b1) $display("FAIL dbz_flag got=%b exp=1", d); else pass_count++;
    total++; if (e !== 33) $display("FAIL dbz_latency got=%0d exp=33", e); else pass_count++;
    @(negedge clock);
    total++; if (div_by_zero !== 1'b0) $display("FAIL dbz_pulse_width got=%b exp=0", div_by_zero); else pass_count++;
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [64:0] exp_v;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic d;
    int e;
    bit pm, bb;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp_v = model(o, a, b);
      run_op(o, a, b, p, d, e, pm, bb);
      total++;
      if (p !== exp_v[63:0] || d !== exp_v[64] || e !== 33)
        $display("FAIL random_%0d op=%b a=%h b=%h got=%b/%h/%0d exp=%b/%h/33", i, o, a, b, d, p, e, exp_v[64], exp_v[63:0]);
      else pass_count++;
      if ($urandom_range(0, 1) == 0) @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_ignore_start_then_back_to_back();
    logic [64:0] exp1, exp2;
    logic [63:0] p;
    logic d;
    int e;
    bit pm, bb;
    exp1 = model(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    exp2 = model(2'b11, 32'hCAFE_F00D, 32'd13);
    op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e = 1;
    while (done !== 1'b1 && e < 40) begin
      start = (e == 10);
      if (e == 10) begin op = 2'b11; src_a = 32'h0000_0064; src_b = 32'd3; end
      @(negedge clock);
      e++;
    end
    start = 1'b0;
    total++; if (prod !== exp1[63:0]) $display("FAIL ignore_start_prod got=%h exp=%h", prod, exp1[63:0]); else pass_count++;
    total++; if (e !== 33) $display("FAIL ignore_start_latency got=%0d exp=33", e); else pass_count++;
    run_op(2'b11, 32'hCAFE_F00D, 32'd13, p, d, e, pm, bb);
    total++; if (p !== exp2[63:0]) $display("FAIL b2b_prod got=%h exp=%h", p, exp2[63:0]); else pass_count++;
    total++; if (e !== 33) $display("FAIL b2b_latency got=%0d exp=33", e); else pass_count++;
    total++; if (bb || pm) $display("FAIL b2b_run got=busy_bad:%b prod_moved:%b exp=0:0", bb, pm); else pass_count++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    logic [64:0] exp_v;
    logic [63:0] p;
    logic d;
    int e;
    bit pm, bb;
    op = 2'b01; src_a = 32'h0F0F_0F0F; src_b = 32'h3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    total++; if (busy !== 1'b1) $display("FAIL mid_run_busy got=%b exp=1", busy); else pass_count++;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass_count++;
    total++; if (prod !== 64'd0) $display("FAIL abort_prod got=%h exp=0", prod); else pass_count++;
    @(negedge clock);
    reset = 1'b0;
    exp_v = model(2'b11, 32'h0000_03E8, 32'd9);
    run_op(2'b11, 32'h0000_03E8, 32'd9, p, d, e, pm, bb);
    total++; if (e !== 33) $display("FAIL post_reset_latency got=%0d exp=33", e); else pass_count++;
    total++; if (pm) $display("FAIL post_reset_stray_result got=changed exp=zero until done"); else pass_count++;
    total++; if (p !== exp_v[63:0]) $display("FAIL post_reset_prod got=%h exp=%h", p, exp_v[63:0]); else pass_count++;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_mult_corners();
    test_div_corners();
    test_random();
    test_ignore_start_then_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_count, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-004 SHALL have port op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port src_a, input, 32 bits: multiplicand or dividend (rs value).
REQ-006 SHALL have port src_b, input, 32 bits: multiplier or divisor (rt value).
REQ-007 SHALL have port busy, output, 1 bit: operation in progress; start is ignored while busy is high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking prod valid.
REQ-009 SHALL have port prod, output, 64 bits: {hi, lo} result, fed to the pipeline prod path for the hi/lo writeback.
REQ-010 SHALL have port div_by_zero, output, 1 bit: divide with src_b==0, valid while done is high.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE; busy SHALL be 1 only in RUN.
REQ-012 SHALL, when start=1 in IDLE or DONE, latch op, src_a and src_b, clear the 5-bit iteration counter, and enter RUN.
REQ-013 SHALL, in RUN, execute exactly one iteration per cycle (shift-add multiply, restoring divide), processing 32 iterations total.
REQ-014 SHALL enter DONE on the edge that completes iteration 32, so done=1 during the 33rd cycle after the start edge; prod SHALL update on that same edge.
REQ-015 SHALL go from DONE to IDLE on the next edge unless start=1 (back-to-back start permitted).
REQ-016 SHALL hold prod stable from DONE until the next accepted start completes; prod SHALL NOT change during RUN.
REQ-017 SHALL ignore start and all operand changes while in RUN.
REQ-018 SHALL, for mult/multu, produce prod = full 64-bit product.
REQ-019 SHALL, for div/divu, produce prod[63:32] = remainder (hi) and prod[31:0] = quotient (lo).
REQ-020 SHALL, for divide with src_b==0, still take 32 cycles and produce hi=src_a, lo=0xFFFFFFFF, div_by_zero=1.
REQ-021 SHALL drive div_by_zero=0 for all multiply ops and non-zero divides.
REQ-022 SHALL keep counter wrap-around internal: 31 -> exit RUN; no 33rd iteration.

Reset
REQ-023 SHALL, on reset at any time including mid-RUN, abort the operation, enter IDLE, and force busy=0, done=0, prod=0, div_by_zero=0, and counter=0.
REQ-024 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL use macro MULT_DIV_SIGNED_EN.
- When defined: mult/div operate on two's-complement magnitudes and negate the result as required; the quotient sign is sign(a) XOR sign(b), and the remainder takes the sign of the dividend.
- When undefined: op[0] is ignored, mult behaves as multu, div behaves as divu, and no sign logic is synthesized.

Verification
REQ-026 SHALL verify multu 0xFFFFFFFF*0xFFFFFFFF -> prod=0xFFFFFFFE_00000001, with done exactly 33 cycles after start.
REQ-027 SHALL verify, with MULT_DIV_SIGNED_EN, mult 0xFFFFFFFD*7 -> prod=0xFFFFFFFF_FFFFFFEB; without the macro -> prod=0x00000006_FFFFFFEB.
REQ-028 SHALL verify divu 100/7 -> hi=2, lo=14; and, with the macro, div 0xFFFFFFF9/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-029 SHALL verify divu 0x1234/0 -> hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1 for exactly one cycle.
REQ-030 SHALL verify that start with new operands at cycle 10 of RUN is ignored and the first result is unchanged; a start during DONE begins a new 32-cycle run.
REQ-031 SHALL verify that reset asserted at cycle 15 of RUN -> busy=0, prod=0 immediately, and no done pulse follows.
